// File: rtl/sap_control_unit.sv
// sap_control_unit -- microcode sequencer for the 8-bit SAP CPU.
//
// Walks every instruction through fetch (T0, T1) and execute (T2..T4).
// Each instruction returns to T0 after its last meaningful step.
// All strobes are combinational from the registered step, the opcode and,
// in T2 only, the carry/zero flags.
//
// Only one of pc_enable, ram_enable, ir_enable, a_enable and alu_enable is
// ever decoded in a given step, so the shared bus never has two drivers.
//
// Parameter HALT_ON_ILLEGAL:
//   0 : opcodes 9..D behave as a 3-cycle NOP.
//   1 : opcodes 9..D stop the machine in HALT.
//
// Optional build macro CU_RUN_GATE_EN:
//   Adds an input 'run'. A new instruction (T0) starts only while run=1.
//   Otherwise the unit idles in WAIT (t_state=6, all strobes low).
//   An instruction already in flight always completes.
//   Without the macro the unit behaves as if run were tied high.
//
// Reset is synchronous and active-high. While rst is high every strobe is
// forced low and halted reads 0, so no register is disturbed mid-instruction.

module sap_control_unit #(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CU_RUN_GATE_EN
  input  logic       run,
`endif
  input  logic [3:0] opcode,
  input  logic       flag_carry,
  input  logic       flag_zero,
  output logic       pc_enable,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_enable,
  output logic       ram_load,
  output logic       ir_load,
  output logic       ir_enable,
  output logic       a_load,
  output logic       a_enable,
  output logic       b_load,
  output logic       alu_enable,
  output logic       alu_sub,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] t_state
);

  // The state encoding doubles as the externally visible t_state value.
  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_WAIT = 3'd6,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state_reg;
  state_t state_next;

  // Where the sequencer goes whenever a new instruction may begin.
  logic   run_ok;
  state_t fetch_entry;

`ifdef CU_RUN_GATE_EN
  assign run_ok = run;
`else
  assign run_ok = 1'b1;
`endif

  assign fetch_entry = run_ok ? ST_T0 : ST_WAIT;

  // Opcodes 9..D are not part of the instruction set.
  logic op_illegal;
  assign op_illegal = (opcode >= 4'h9) && (opcode <= 4'hD);

  // State register; reset always restarts at the fetch entry point.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= fetch_entry;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-step selection and strobe decode.
  // The whole decode is suppressed while rst is high.
  always_comb begin
    state_next = state_reg;
    pc_enable  = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    mar_load   = 1'b0;
    ram_enable = 1'b0;
    ram_load   = 1'b0;
    ir_load    = 1'b0;
    ir_enable  = 1'b0;
    a_load     = 1'b0;
    a_enable   = 1'b0;
    b_load     = 1'b0;
    alu_enable = 1'b0;
    alu_sub    = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;

    if (!rst) begin
      case (state_reg)
        // Fetch: address the instruction.
        ST_T0: begin
          pc_enable  = 1'b1;
          mar_load   = 1'b1;
          state_next = ST_T1;
        end

        // Fetch: read it into IR and advance the program counter.
        ST_T1: begin
          ram_enable = 1'b1;
          ir_load    = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_T2;
        end

        // First execute step: the only step that looks at the flags.
        ST_T2: begin
          state_next = fetch_entry;
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_enable  = 1'b1;
              mar_load   = 1'b1;
              state_next = ST_T3;
            end
            OP_LDI: begin
              ir_enable = 1'b1;
              a_load    = 1'b1;
            end
            OP_JMP: begin
              ir_enable = 1'b1;
              pc_load   = 1'b1;
            end
            OP_JC: begin
              ir_enable = flag_carry;
              pc_load   = flag_carry;
            end
            OP_JZ: begin
              ir_enable = flag_zero;
              pc_load   = flag_zero;
            end
            OP_OUT: begin
              a_enable = 1'b1;
              out_load = 1'b1;
            end
            OP_HLT: begin
              state_next = ST_HALT;
            end
            default: begin
              // NOP and the illegal opcodes have an empty T2.
              if (op_illegal && HALT_ON_ILLEGAL) begin
                state_next = ST_HALT;
              end
            end
          endcase
        end

        // Second execute step: memory operand transfer.
        ST_T3: begin
          state_next = fetch_entry;
          case (opcode)
            OP_LDA: begin
              ram_enable = 1'b1;
              a_load     = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_enable = 1'b1;
              b_load     = 1'b1;
              state_next = ST_T4;
            end
            OP_STA: begin
              a_enable = 1'b1;
              ram_load = 1'b1;
            end
            default: begin
            end
          endcase
        end

        // Third execute step: ALU result back into A, flags captured.
        ST_T4: begin
          state_next = fetch_entry;
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_enable = 1'b1;
            a_load     = 1'b1;
            flags_load = 1'b1;
            alu_sub    = (opcode == OP_SUB);
          end
        end

        // Idle between instructions until the unit is allowed to run.
        ST_WAIT: begin
          state_next = fetch_entry;
        end

        // Terminal state; only reset leaves it.
        ST_HALT: begin
          state_next = ST_HALT;
        end

        default: begin
          state_next = ST_T0;
        end
      endcase
    end
  end

  // Status outputs straight from the registered state.
  assign halted  = (state_reg == ST_HALT) && !rst;
  assign t_state = state_reg;

endmodule

// File: tb/tb_sap_control_unit.sv
// tb_sap_control_unit -- table-driven check of sap_control_unit.
//
// Two instances share all inputs:
//   dut0 has HALT_ON_ILLEGAL=0.
//   dut1 has HALT_ON_ILLEGAL=1.
// Each table row is one clock cycle and holds the inputs for that cycle.
// It also holds the expected strobes, t_state and halted value for each
// instance.
// Inputs are driven after the falling edge and compared 1 ns later.
// The bus-driver and PC-strobe invariants are checked on every cycle.

module tb_sap_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] opcode;
  logic       flag_carry;
  logic       flag_zero;
`ifdef CU_RUN_GATE_EN
  logic       run;
`endif

  // Strobe order, from bit 14 down to bit 0:
  //   pc_enable, pc_inc, pc_load, mar_load, ram_enable, ram_load,
  //   ir_load, ir_enable, a_load, a_enable, b_load, alu_enable,
  //   alu_sub, flags_load, out_load
  logic [14:0] s0;
  logic [14:0] s1;
  logic [2:0]  ts0;
  logic [2:0]  ts1;
  logic        h0;
  logic        h1;

  localparam logic [14:0] PE   = 15'h4000;
  localparam logic [14:0] PCI  = 15'h2000;
  localparam logic [14:0] PCL  = 15'h1000;
  localparam logic [14:0] MAR  = 15'h0800;
  localparam logic [14:0] RE   = 15'h0400;
  localparam logic [14:0] RAML = 15'h0200;
  localparam logic [14:0] IRL  = 15'h0100;
  localparam logic [14:0] IRE  = 15'h0080;
  localparam logic [14:0] AL   = 15'h0040;
  localparam logic [14:0] AE   = 15'h0020;
  localparam logic [14:0] BL   = 15'h0010;
  localparam logic [14:0] ALUE = 15'h0008;
  localparam logic [14:0] SUBS = 15'h0004;
  localparam logic [14:0] FL   = 15'h0002;
  localparam logic [14:0] OUTL = 15'h0001;
  localparam logic [14:0] NONE = 15'h0000;
  localparam logic [14:0] F0   = PE | MAR;
  localparam logic [14:0] F1   = RE | IRL | PCI;
  localparam logic [14:0] BUS_EN = PE | RE | IRE | AE | ALUE;

  int errors = 0;
  int checks = 0;

  sap_control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .rst(rst),
`ifdef CU_RUN_GATE_EN
    .run(run),
`endif
    .opcode(opcode), .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_enable(s0[14]), .pc_inc(s0[13]), .pc_load(s0[12]), .mar_load(s0[11]),
    .ram_enable(s0[10]), .ram_load(s0[9]), .ir_load(s0[8]), .ir_enable(s0[7]),
    .a_load(s0[6]), .a_enable(s0[5]), .b_load(s0[4]), .alu_enable(s0[3]),
    .alu_sub(s0[2]), .flags_load(s0[1]), .out_load(s0[0]),
    .halted(h0), .t_state(ts0)
  );

  sap_control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .rst(rst),
`ifdef CU_RUN_GATE_EN
    .run(run),
`endif
    .opcode(opcode), .flag_carry(flag_carry), .flag_zero(flag_zero),
    .pc_enable(s1[14]), .pc_inc(s1[13]), .pc_load(s1[12]), .mar_load(s1[11]),
    .ram_enable(s1[10]), .ram_load(s1[9]), .ir_load(s1[8]), .ir_enable(s1[7]),
    .a_load(s1[6]), .a_enable(s1[5]), .b_load(s1[4]), .alu_enable(s1[3]),
    .alu_sub(s1[2]), .flags_load(s1[1]), .out_load(s1[0]),
    .halted(h1), .t_state(ts1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [14:0] s0;
    logic [2:0]  ts0;
    logic        h0;
    logic [14:0] s1;
    logic [2:0]  ts1;
    logic        h1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] op, logic c, logic z,
                              logic [14:0] es0, logic [2:0] et0, logic eh0,
                              logic [14:0] es1, logic [2:0] et1, logic eh1);
    vec_t v;
    v.rst = r;
    v.op  = op;
    v.c   = c;
    v.z   = z;
    v.s0  = es0;
    v.ts0 = et0;
    v.h0  = eh0;
    v.s1  = es1;
    v.ts1 = et1;
    v.h1  = eh1;
    return v;
  endfunction

  // Row where both instances are expected to agree.
  function automatic void add2(logic r, logic [3:0] op, logic c, logic z,
                               logic [14:0] es, logic [2:0] et, logic eh);
    vecs.push_back(mk(r, op, c, z, es, et, eh, es, et, eh));
  endfunction

  task automatic chk(string name, int row, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs, then compare everything against the record.
  task automatic apply(int row, vec_t v);
    logic [14:0] act;
    @(negedge clk);
    rst        = v.rst;
    opcode     = v.op;
    flag_carry = v.c;
    flag_zero  = v.z;
    #1;
    $display("row %0d rst=%0b op=%h c=%0b z=%0b | u0 t=%0d s=%h h=%0b | u1 t=%0d s=%h h=%0b",
             row, v.rst, v.op, v.c, v.z, ts0, s0, h0, ts1, s1, h1);
    chk("strobes_u0", row, s0, v.s0);
    chk("t_state_u0", row, {12'd0, ts0}, {12'd0, v.ts0});
    chk("halted_u0",  row, {14'd0, h0}, {14'd0, v.h0});
    chk("strobes_u1", row, s1, v.s1);
    chk("t_state_u1", row, {12'd0, ts1}, {12'd0, v.ts1});
    chk("halted_u1",  row, {14'd0, h1}, {14'd0, v.h1});

    act = {14'd0, ($countones(s0 & BUS_EN) <= 1)};
    chk("bus_onehot_u0", row, act, 15'd1);
    act = {14'd0, ($countones(s1 & BUS_EN) <= 1)};
    chk("bus_onehot_u1", row, act, 15'd1);
    act = {14'd0, !(s0[13] && s0[12])};
    chk("pc_inc_load_u0", row, act, 15'd1);
    act = {14'd0, !(s1[13] && s1[12])};
    chk("pc_inc_load_u1", row, act, 15'd1);
  endtask

  initial begin
    int row;
    rst        = 1'b1;
    opcode     = 4'h0;
    flag_carry = 1'b0;
    flag_zero  = 1'b0;
`ifdef CU_RUN_GATE_EN
    run        = 1'b1;
`endif

    // Reset held: state already T0, strobes gated.
    add2(1, 4'h5, 0, 0, NONE, 3'd0, 0);

    // LDI: 3 cycles, then the next T0.
    add2(0, 4'h5, 0, 0, F0,       3'd0, 0);
    add2(0, 4'h5, 0, 0, F1,       3'd1, 0);
    add2(0, 4'h5, 0, 0, IRE | AL, 3'd2, 0);

    // SUB: 5 cycles, alu_sub only in T4.
    add2(0, 4'h3, 0, 0, F0,                     3'd0, 0);
    add2(0, 4'h3, 0, 0, F1,                     3'd1, 0);
    add2(0, 4'h3, 0, 0, IRE | MAR,              3'd2, 0);
    add2(0, 4'h3, 0, 0, RE | BL,                3'd3, 0);
    add2(0, 4'h3, 0, 0, ALUE | AL | FL | SUBS,  3'd4, 0);

    // JC with carry clear: no jump, empty T2.
    add2(0, 4'h7, 0, 0, F0,   3'd0, 0);
    add2(0, 4'h7, 0, 0, F1,   3'd1, 0);
    add2(0, 4'h7, 0, 0, NONE, 3'd2, 0);

    // JC with carry set.
    add2(0, 4'h7, 1, 0, F0,        3'd0, 0);
    add2(0, 4'h7, 1, 0, F1,        3'd1, 0);
    add2(0, 4'h7, 1, 0, IRE | PCL, 3'd2, 0);

    // JZ looks only at zero.
    add2(0, 4'h8, 0, 1, F0,        3'd0, 0);
    add2(0, 4'h8, 0, 1, F1,        3'd1, 0);
    add2(0, 4'h8, 0, 1, IRE | PCL, 3'd2, 0);
    add2(0, 4'h8, 1, 0, F0,        3'd0, 0);
    add2(0, 4'h8, 1, 0, F1,        3'd1, 0);
    add2(0, 4'h8, 1, 0, NONE,      3'd2, 0);

    // LDA; opcode shows HLT during fetch, which must be ignored.
    add2(0, 4'hF, 0, 0, F0,        3'd0, 0);
    add2(0, 4'hF, 0, 0, F1,        3'd1, 0);
    add2(0, 4'h1, 0, 0, IRE | MAR, 3'd2, 0);
    add2(0, 4'h1, 0, 0, RE | AL,   3'd3, 0);

    // STA.
    add2(0, 4'h4, 0, 0, F0,        3'd0, 0);
    add2(0, 4'h4, 0, 0, F1,        3'd1, 0);
    add2(0, 4'h4, 0, 0, IRE | MAR, 3'd2, 0);
    add2(0, 4'h4, 0, 0, AE | RAML, 3'd3, 0);

    // JMP, OUT, NOP.
    add2(0, 4'h6, 0, 0, F0,        3'd0, 0);
    add2(0, 4'h6, 0, 0, F1,        3'd1, 0);
    add2(0, 4'h6, 0, 0, IRE | PCL, 3'd2, 0);
    add2(0, 4'hE, 0, 0, F0,        3'd0, 0);
    add2(0, 4'hE, 0, 0, F1,        3'd1, 0);
    add2(0, 4'hE, 0, 0, AE | OUTL, 3'd2, 0);
    add2(0, 4'h0, 0, 0, F0,        3'd0, 0);
    add2(0, 4'h0, 0, 0, F1,        3'd1, 0);
    add2(0, 4'h0, 0, 0, NONE,      3'd2, 0);

    // ADD interrupted by reset in T3, then LDI restarts cleanly.
    add2(0, 4'h2, 0, 0, F0,        3'd0, 0);
    add2(0, 4'h2, 0, 0, F1,        3'd1, 0);
    add2(0, 4'h2, 0, 0, IRE | MAR, 3'd2, 0);
    add2(1, 4'h2, 0, 0, NONE,      3'd3, 0);
    add2(0, 4'h5, 0, 0, F0,        3'd0, 0);
    add2(0, 4'h5, 0, 0, F1,        3'd1, 0);
    add2(0, 4'h5, 0, 0, IRE | AL,  3'd2, 0);

    // Illegal opcode A: NOP on unit 0, HALT on unit 1.
    add2(0, 4'hA, 0, 0, F0,   3'd0, 0);
    add2(0, 4'hA, 0, 0, F1,   3'd1, 0);
    add2(0, 4'hA, 0, 0, NONE, 3'd2, 0);
    vecs.push_back(mk(0, 4'h0, 0, 0, F0, 3'd0, 0, NONE, 3'd7, 1));
    vecs.push_back(mk(0, 4'h0, 0, 0, F1, 3'd1, 0, NONE, 3'd7, 1));
    vecs.push_back(mk(1, 4'h0, 0, 0, NONE, 3'd2, 0, NONE, 3'd7, 0));

    repeat (2) @(posedge clk);
    row = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(row, vecs[i]);
      row++;
    end

    // HLT: halted from the fourth cycle, immune to inputs, left only by reset.
    apply(row, mk(0, 4'hF, 0, 0, F0,   3'd0, 0, F0,   3'd0, 0)); row++;
    apply(row, mk(0, 4'hF, 0, 0, F1,   3'd1, 0, F1,   3'd1, 0)); row++;
    apply(row, mk(0, 4'hF, 0, 0, NONE, 3'd2, 0, NONE, 3'd2, 0)); row++;
    for (int i = 0; i < 22; i++) begin
      logic [3:0] rop;
      logic       rc;
      logic       rz;
      rop = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      rz  = 1'($urandom_range(0, 1));
      apply(row, mk(0, rop, rc, rz, NONE, 3'd7, 1, NONE, 3'd7, 1));
      row++;
    end
    apply(row, mk(1, 4'h5, 0, 0, NONE, 3'd7, 0, NONE, 3'd7, 0)); row++;
    apply(row, mk(0, 4'h5, 0, 0, F0,   3'd0, 0, F0,   3'd0, 0)); row++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sap_control_unit.md
Name: sap_control_unit

Overview:
- Microcode sequencer for the 8-bit SAP CPU.
- Steps each instruction through fetch (T0–T1) and execute (T2–T4) states.
- Drives every bus-enable and register-load strobe: program counter (pc_inc/pc_load/pc_enable), MAR, RAM, IR, A, B, ALU, flags, output register.
- Decodes the IR opcode nibble plus the carry/zero flags; owns the shared bus discipline: at most one *_enable per cycle.

Parameters:
- HALT_ON_ILLEGAL, 0, 1: opcodes 9–D enter HALT; 0: they execute as NOP.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  4  IR[7:4]; valid from T2 onward
- flag_carry  in  1  carry flag from flags register
- flag_zero  in  1  zero flag from flags register
- pc_enable, pc_inc, pc_load  out  1 each  program counter strobes
- mar_load  out  1  load MAR from bus
- ram_enable, ram_load  out  1 each  RAM drives bus / RAM writes bus
- ir_load, ir_enable  out  1 each  load IR / drive IR[3:0] zero-extended onto bus
- a_load, a_enable, b_load  out  1 each  register strobes
- alu_enable, alu_sub  out  1 each  ALU drives bus / subtract select
- flags_load, out_load  out  1 each  capture flags / load output register
- halted  out  1  high while in HALT
- t_state  out  3  current step 0–4; 7 in HALT

Behaviour:
- States: T0, T1, T2, T3, T4, HALT. Registered state; all strobes are combinational from the state and the opcode.
- Reset:
  - While rst=1, all strobes are 0 and halted=0.
  - Next state is T0 (t_state=0), with or without HALT in progress and at any step mid-instruction.
- Fetch:
  - T0: pc_enable, mar_load.
  - T1: ram_enable, ir_load, pc_inc.
- Execute (unlisted steps assert nothing):
  - NOP(0): T2 empty.
  - LDA(1): T2 ir_enable+mar_load; T3 ram_enable+a_load.
  - ADD(2): T2 ir_enable+mar_load; T3 ram_enable+b_load; T4 alu_enable+a_load+flags_load.
  - SUB(3): as ADD, with alu_sub=1 in T4 only.
  - STA(4): T2 ir_enable+mar_load; T3 a_enable+ram_load.
  - LDI(5): T2 ir_enable+a_load.
  - JMP(6): T2 ir_enable+pc_load.
  - JC(7): T2 ir_enable+pc_load only if flag_carry=1, else empty.
  - JZ(8): as JC, using flag_zero.
  - OUT(E): T2 a_enable+out_load.
  - HLT(F): T2 empty, next state HALT.
- Early termination: after an instruction's last step, the next state is T0.
  - NOP/LDI/JMP/JC/JZ/OUT: 3 cycles.
  - LDA/STA: 4 cycles.
  - ADD/SUB: 5 cycles.
- Flags: sampled combinationally in T2 only.
- HALT: all strobes 0, halted=1, t_state=7; only rst exits.
- Opcodes 9–D: NOP timing, or HALT when HALT_ON_ILLEGAL=1.
- Invariants:
  - At most one of pc_enable, ram_enable, ir_enable, a_enable, alu_enable is high in any cycle.
  - pc_inc and pc_load are never high together.
- opcode changes outside T2–T4 are ignored.

Optional Feature:
- Macro CU_RUN_GATE_EN.
- When defined:
  - Adds input run (1 bit).
  - A new T0 is entered only on a cycle where run=1. Otherwise the unit waits in a WAIT state: t_state=6, all strobes 0.
  - An instruction in flight always completes regardless of run.
  - Reset goes to WAIT when run=0.
- When undefined: the port is absent and behaviour is as if run=1.

Test Plan:
- Reset release then opcode=5 (LDI) → cycle1 pc_enable+mar_load; cycle2 ram_enable+ir_load+pc_inc; cycle3 ir_enable+a_load; cycle4 t_state=0.
- opcode=3 (SUB) → T4 shows alu_enable=1, a_load=1, flags_load=1, alu_sub=1; alu_sub=0 in T0–T3; 5-cycle period.
- opcode=7 with flag_carry=0 → T2 all strobes 0, pc_load never high; with flag_carry=1 → T2 ir_enable+pc_load=1.
- opcode=F → halted=1 and t_state=7 from cycle 4 for 20+ cycles with all strobes 0; rst pulse → t_state=0 next cycle.
- opcode=A with HALT_ON_ILLEGAL=0 → 3-cycle NOP; with HALT_ON_ILLEGAL=1 → halted=1.
- rst asserted in T3 of ADD → strobes 0 that cycle, t_state=0 next; bus-enable one-hot assertion checked on every cycle of all benches.
